// File: rtl/tm_pkg.sv
// tm_pkg: shared state encoding and constants for the TM inference sequencer
package tm_pkg;
   localparam int CLAUSEN = 10;
   localparam int CLASSN = 10;
   localparam int WPC = 5;
   localparam int WDEPTH = CLASSN * WPC;
   localparam int CW = $clog2(CLASSN);
   localparam int DW = 256;
   localparam int AW = 9;
   typedef enum logic [3:0] {
      IDLE, LOAD_CL, LOAD_WT, SETTLE, IMG_RST, START, WAIT, RESULT, DONE
   } state_t;
endpackage

// File: rtl/tm_cfg_writer.sv
// tm_cfg_writer: config stream to clause/weight BRAM writer with registered write strobes
module tm_cfg_writer
   import tm_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          sel,
   input  logic [AW-1:0] limit,
   input  logic          s_valid,
   input  logic [DW-1:0] s_data,
   output logic          s_ready,
   output logic          last,
   output logic          we_cl,
   output logic          we_wt,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] wdata
);
   logic [AW-1:0] cnt;
   logic          beat;
   assign s_ready = en;
   assign beat = en & s_valid;
   assign last = beat && cnt == limit - AW'(1);
   // one write per accepted beat, issued next cycle; the strobe carries its target so a phase change cannot misroute it
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         addr <= '0;
         wdata <= '0;
         we_cl <= 1'b0;
         we_wt <= 1'b0;
      end else begin
         we_cl <= beat & ~sel;
         we_wt <= beat & sel;
         if (beat) begin
            addr <= cnt;
            wdata <= s_data;
            cnt <= last ? '0 : cnt + AW'(1);
         end
      end
   end
endmodule

// File: rtl/tm_infer_sequencer.sv
// tm_infer_sequencer: loads clause/weight BRAMs from the config stream, then runs images and returns winning classes
module tm_infer_sequencer
   import tm_pkg::*;
#(
   parameter int TIMEOUT = 4096
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [15:0]   n_images,
   input  logic [8:0]    clauses,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_data,
   output logic [DW-1:0] clause_write,
   output logic          wea,
   output logic [31:0]   bram_addr_a,
   output logic [DW-1:0] weight_write,
   output logic          wea2,
   output logic [31:0]   bram_addr_a2,
   output logic          img_rst,
   output logic          done_rmu,
   input  logic          core_done,
   input  logic [CW-1:0] core_class,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [CW-1:0] res_class,
   output logic [15:0]   res_index,
   output logic          busy,
   output logic          err_timeout
);
   localparam int TW = $clog2(TIMEOUT);
   state_t        state;
   logic [15:0]   n_img, img_cnt;
   logic [AW-1:0] n_cl, addr;
   logic [TW-1:0] tcnt;
   logic          settle, wr_last;
   logic [DW-1:0] wdata;

   tm_cfg_writer u_wr (
      .clk     (clk),
      .reset   (reset),
      .en      (state == LOAD_CL || state == LOAD_WT),
      .sel     (state == LOAD_WT),
      .limit   (state == LOAD_WT ? AW'(WDEPTH) : n_cl),
      .s_valid (s_valid),
      .s_data  (s_data),
      .s_ready (s_ready),
      .last    (wr_last),
      .we_cl   (wea),
      .we_wt   (wea2),
      .addr    (addr),
      .wdata   (wdata)
   );

   assign clause_write = wdata;
   assign weight_write = wdata;
   assign bram_addr_a = {{(32-AW){1'b0}}, addr};
   assign bram_addr_a2 = {{(32-AW){1'b0}}, addr};
   assign busy = state != IDLE;

   // run control: load phases, settle, then per image reset/start/wait/return; pulses default low each cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         n_img <= '0;
         n_cl <= '0;
         img_cnt <= '0;
         tcnt <= '0;
         settle <= 1'b0;
         img_rst <= 1'b0;
         done_rmu <= 1'b0;
         res_valid <= 1'b0;
         res_class <= '0;
         res_index <= '0;
         err_timeout <= 1'b0;
      end else begin
         img_rst <= 1'b0;
         done_rmu <= 1'b0;
         case (state)
            IDLE: if (start) begin
               n_img <= n_images;
               n_cl <= clauses;
               img_cnt <= '0;
               err_timeout <= 1'b0;
               state <= clauses != 9'd0 ? LOAD_CL : DONE;
            end
            LOAD_CL: if (wr_last) state <= LOAD_WT;
            LOAD_WT: if (wr_last) begin
               state <= SETTLE;
               settle <= 1'b0;
            end
            SETTLE: begin
               settle <= 1'b1;
               if (settle) begin
                  state <= n_img != 16'd0 ? IMG_RST : DONE;
                  img_rst <= n_img != 16'd0;
               end
            end
            IMG_RST: begin
               done_rmu <= 1'b1;
               state <= START;
            end
            START: begin
               tcnt <= '0;
               state <= WAIT;
            end
            WAIT: if (core_done) begin
               res_valid <= 1'b1;
               res_class <= core_class;
               res_index <= img_cnt;
               state <= RESULT;
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
               err_timeout <= 1'b1;
               state <= DONE;
            end else begin
               tcnt <= tcnt + TW'(1);
            end
            RESULT: if (res_ready) begin
               res_valid <= 1'b0;
               img_cnt <= img_cnt + 16'd1;
               state <= img_cnt + 16'd1 == n_img ? DONE : IMG_RST;
               img_rst <= img_cnt + 16'd1 != n_img;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tm_infer_sequencer.sv
// tb_tm_infer_sequencer: randomized load/run/timeout/abort scenarios scored against a stream-order model
module tb_tm_infer_sequencer;
   import tm_pkg::*;
   localparam int TO = 64;

   logic          clk = 1'b0, reset = 1'b1, start = 1'b0, s_valid = 1'b0;
   logic          core_done = 1'b0, res_ready = 1'b0;
   logic [15:0]   n_images = '0;
   logic [8:0]    clauses = '0;
   logic [DW-1:0] s_data = '0;
   logic [CW-1:0] core_class = '0;
   logic          s_ready, wea, wea2, img_rst, done_rmu, res_valid, busy, err_timeout;
   logic [DW-1:0] clause_write, weight_write;
   logic [31:0]   bram_addr_a, bram_addr_a2;
   logic [CW-1:0] res_class;
   logic [15:0]   res_index;

   tm_infer_sequencer #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .n_images(n_images), .clauses(clauses),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .clause_write(clause_write), .wea(wea), .bram_addr_a(bram_addr_a),
      .weight_write(weight_write), .wea2(wea2), .bram_addr_a2(bram_addr_a2),
      .img_rst(img_rst), .done_rmu(done_rmu), .core_done(core_done), .core_class(core_class),
      .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class), .res_index(res_index),
      .busy(busy), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;
   int cl_a[$], wt_a[$];
   logic [DW-1:0] cl_d[$], wt_d[$];
   int n_irst = 0, n_rmu = 0, n_wide = 0;
   logic irst_q = 1'b0, rmu_q = 1'b0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (wea) begin
         cl_a.push_back(int'(bram_addr_a));
         cl_d.push_back(clause_write);
      end
      if (wea2) begin
         wt_a.push_back(int'(bram_addr_a2));
         wt_d.push_back(weight_write);
      end
      if (img_rst && !irst_q) n_irst <= n_irst + 1;
      if (done_rmu && !rmu_q) n_rmu <= n_rmu + 1;
      if ((img_rst && irst_q) || (done_rmu && rmu_q)) n_wide <= n_wide + 1;
      irst_q <= img_rst;
      rmu_q <= done_rmu;
   end

   task automatic chk_zero(input string tag);
      check({tag, "_strobes"}, {s_ready, wea, wea2, img_rst, done_rmu, res_valid, busy, err_timeout}, '0);
      check({tag, "_addr"}, {bram_addr_a, bram_addr_a2, res_index, res_class}, '0);
   endtask

   // mode: 0 normal, 1 abort in LOAD_WT, 2 abort in WAIT, 3 core never answers
   task automatic run_job(input int ncl, input int nimg, input bit gaps, input bit stall, input int mode);
      logic [DW-1:0] words[$];
      int cb, wb, ib, rb, wd, cyc, total, eimg, target;
      cb = cl_a.size(); wb = wt_a.size(); ib = n_irst; rb = n_rmu; wd = n_wide;
      total = ncl == 0 ? 0 : ncl + WDEPTH;
      eimg = ncl == 0 ? 0 : nimg;
      target = mode == 1 ? ncl + 10 : total;
      clauses = 9'(ncl);
      n_images = 16'(nimg);
      start = 1'b1;
      tick;
      start = 1'b0;
      check("busy_after_start", busy, 1);
      check("err_cleared", err_timeout, 0);
      cyc = 0;
      while (words.size() < target && cyc < 3000) begin
         s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         s_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         core_done = 1'($urandom_range(0, 1));
         start = $urandom_range(0, 7) == 0;
         if (s_valid && s_ready) words.push_back(s_data);
         tick;
         cyc++;
      end
      s_valid = 1'b0;
      core_done = 1'b0;
      start = 1'b0;
      check("load_beats", words.size(), target);
      if (mode == 1) begin
         reset = 1'b1;
         tick;
         reset = 1'b0;
         chk_zero("abort_wt");
         return;
      end
      for (int i = 0; i < eimg; i++) begin
         int d, c, k, irb;
         d = $urandom_range(1, 40);
         c = $urandom_range(0, CLASSN - 1);
         cyc = 0;
         while (!done_rmu && cyc < 50) begin
            tick;
            cyc++;
         end
         check("rmu_seen", done_rmu, 1);
         if (mode == 3) begin
            cyc = 0;
            while (!err_timeout && cyc < 200) begin
               tick;
               cyc++;
            end
            check("timeout_cycles", cyc, TO + 1);
            check("to_no_result", res_valid, 0);
            tick;
            check("idle_after_to", busy, 0);
            check("to_sticky", err_timeout, 1);
            return;
         end
         if (mode == 2) begin
            repeat (5) tick;
            reset = 1'b1;
            tick;
            reset = 1'b0;
            chk_zero("abort_wait");
            return;
         end
         start = 1'b1;
         tick;
         start = 1'b0;
         repeat (d - 1) tick;
         core_done = 1'b1;
         core_class = CW'(c);
         tick;
         core_done = 1'b0;
         cyc = 0;
         while (!res_valid && cyc < 10) begin
            tick;
            cyc++;
         end
         check("res_valid", res_valid, 1);
         check("res_class", res_class, c);
         check("res_index", res_index, i);
         k = stall ? $urandom_range(1, 5) : 0;
         irb = n_irst;
         repeat (k) begin
            tick;
            check("hold_valid", res_valid, 1);
            check("hold_class", res_class, c);
         end
         check("no_irst_in_stall", n_irst - irb, 0);
         res_ready = 1'b1;
         tick;
         res_ready = 1'b0;
         check("valid_dropped", res_valid, 0);
      end
      cyc = 0;
      while (busy && cyc < 20) begin
         tick;
         cyc++;
      end
      check("back_to_idle", busy, 0);
      check("n_cl_writes", cl_a.size() - cb, ncl == 0 ? 0 : ncl);
      check("n_wt_writes", wt_a.size() - wb, ncl == 0 ? 0 : WDEPTH);
      for (int i = 0; i < ncl && cb + i < cl_a.size() && i < words.size(); i++) begin
         check("cl_addr", cl_a[cb + i], i);
         check("cl_data", cl_d[cb + i], words[i]);
      end
      for (int i = 0; i < WDEPTH && wb + i < wt_a.size() && ncl + i < words.size(); i++) begin
         check("wt_addr", wt_a[wb + i], i);
         check("wt_data", wt_d[wb + i], words[ncl + i]);
      end
      check("n_img_rst", n_irst - ib, eimg);
      check("n_done_rmu", n_rmu - rb, eimg);
      check("pulse_width", n_wide - wd, 0);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      repeat (3) tick;
      chk_zero("reset");
      reset = 1'b0;
      tick;
      chk_zero("idle");
      run_job(3, 2, 0, 0, 0);
      run_job(3, 3, 1, 1, 0);
      run_job(7, 0, 1, 0, 0);
      run_job(5, 1, 1, 0, 3);
      run_job(0, 4, 0, 0, 0);
      run_job(6, 2, 1, 0, 1);
      run_job(2, 2, 0, 1, 2);
      run_job($urandom_range(1, 20), 3, 1, 1, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/tm_infer_sequencer.md
Name: tm_infer_sequencer

Overview:
Top-level control FSM for the convolutional Tsetlin-machine inference core (clause chain plus class-sum/argmax stage).
- Loads clause words and class-weight words from a 256-bit config stream into the core's clause and weight BRAMs.
- Then runs N images back to back: image reset, start of the remap unit, wait for the core's done pulse.
- Returns each winning class over a valid/ready result interface.
- Sits between the host/DMA stream and the inference core; owns wea/wea2/img_rst/done_rmu generation.

Parameters:
CLAUSEN, 10, number of clause stages in the chain
CLASSN, 10, number of classes
WPC, 5, 256-bit weight words per class (weight BRAM address = class*WPC + offset)
TIMEOUT, 4096, max cycles to wait for core done per image
CW, $clog2(CLASSN), class index width (shared constant)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  one-cycle go pulse; honoured only in IDLE
n_images  in  16  images to run; sampled on start
clauses  in  9  active clause count; sampled on start
s_valid  in  1  config stream valid
s_ready  out  1  config stream ready
s_data  in  256  config word
clause_write  out  256  clause BRAM write data
wea  out  1  clause BRAM write enable
bram_addr_a  out  32  clause BRAM address
weight_write  out  256  weight BRAM write data
wea2  out  1  weight BRAM write enable
bram_addr_a2  out  32  weight BRAM address
img_rst  out  1  per-image core reset pulse
done_rmu  out  1  remap-unit start pulse to core
core_done  in  1  core done pulse
core_class  in  CW  core class_op, valid with core_done
res_valid  out  1  result valid
res_ready  in  1  result accepted
res_class  out  CW  winning class
res_index  out  16  image index of result
busy  out  1  not in IDLE
err_timeout  out  1  sticky timeout flag, cleared on start

Behaviour:
- Reset: FSM to IDLE.
  - All outputs 0, including s_ready, wea, wea2, img_rst, done_rmu, res_valid, busy, err_timeout.
  - Addresses 0; counters 0.
- IDLE: start=1 latches n_images and clauses, clears err_timeout.
  - Next state is LOAD_CL if clauses != 0; if clauses == 0, go to DONE (no results).
  - start in any other state is ignored.
- LOAD_CL: s_ready=1.
  - Each s_valid&s_ready beat registers one write on the next cycle: wea=1, clause_write=s_data, bram_addr_a = clause counter (0..clauses-1).
  - After beat clauses-1 the FSM goes to LOAD_WT.
  - Write is registered, 1-cycle latency; at most one write per cycle.
- LOAD_WT: same handshake. wea2=1, bram_addr_a2 = counter 0..CLASSN*WPC-1, then go to SETTLE.
- SETTLE: 2 cycles, all strobes low; lets the wea/wea2-derived core reset release.
- IMG_RST: img_rst=1 for exactly 1 cycle, then go to START.
- START: done_rmu=1 for exactly 1 cycle; timeout counter cleared; then go to WAIT.
- WAIT: count cycles.
  - core_done=1: capture core_class into res_class and the image counter into res_index; res_valid=1; go to RESULT.
  - Counter reaching TIMEOUT-1 without core_done: err_timeout=1, go to DONE.
  - core_done in the same cycle as timeout: done wins.
- RESULT: hold res_valid/res_class/res_index stable until res_ready.
  - On the handshake: increment the image counter.
  - If count == n_images go to DONE; else go to IMG_RST.
  - The config stream is not consumed during image runs; the image path is fed externally.
- DONE: 1 cycle, then IDLE. busy=0 only in IDLE.
- core_done outside WAIT is ignored. s_ready=0 outside the LOAD states.
- Reset mid-operation: abort immediately to IDLE.
  - Any pending result is dropped.
  - BRAM contents are not the sequencer's concern.
- n_images == 0 after a load: go to DONE after SETTLE; no img_rst is issued.
- Counter widths: clause counter 9 bits; weight counter $clog2(CLASSN*WPC+1) bits; image counter 16 bits; timeout counter $clog2(TIMEOUT) bits. No wrap-around within legal ranges.

Decomposition:
- Shared package tm_pkg holds:
  - state enum (IDLE, LOAD_CL, LOAD_WT, SETTLE, IMG_RST, START, WAIT, RESULT, DONE);
  - CW and the weight-depth constant CLASSN*WPC;
  - BRAM data width 256.
- One natural sub-module, tm_cfg_writer: the stream-to-BRAM writer (handshake, address counter, registered write strobe). It is instantiated once and muxed to clause or weight port by state.

Test Plan:
1. clauses=3, CLASSN=10, WPC=5, stream of 53 words with no gaps -> wea on 3 cycles at addr 0,1,2; wea2 on 50 cycles at addr 0..49; data matches in order.
2. Random s_valid deassertion during load -> no duplicate or skipped addresses; total writes still 3+50.
3. n_images=2, core_done 20 cycles after each done_rmu with core_class 7 then 3, res_ready held high -> results (7,0) and (3,1); exactly 2 img_rst and 2 done_rmu pulses, each 1 cycle wide.
4. res_ready held low 5 cycles -> res_valid/res_class stable, no next img_rst until accept.
5. core_done never arrives, TIMEOUT=64 -> err_timeout=1 at 64 cycles after START, then IDLE; a new start clears err_timeout.
6. reset asserted in WAIT and in LOAD_WT -> next cycle all outputs 0, state IDLE; start during a run is ignored.
